// File: rtl/dmaster_st_packet_arbiter.sv
// dmaster_st_packet_arbiter
//   Packet-level round-robin arbiter sharing one Avalon-ST byte stream
//   between NUM_IN packetised requesters. A grant is held from the first
//   accepted beat through the beat carrying EOP, so packets never interleave.
//   The winning index is emitted on out_channel. The output is a one-entry
//   registered buffer that sustains 1 beat/cycle (load and unload together).
//
// Ports
//   clk               single clock
//   reset_n           asynchronous active-low reset
//   in_valid/in_ready per-requester handshake (NUM_IN bits each)
//   in_data           flattened beats, requester i at [i*DATA_W +: DATA_W]
//   in_startofpacket  per-requester SOP
//   in_endofpacket    per-requester EOP
//   out_ready         downstream ready
//   out_valid         buffer holds a beat
//   out_data          buffered beat data
//   out_channel       granted requester index, zero-extended
//   out_startofpacket buffered SOP
//   out_endofpacket   buffered EOP
//
// state  | meaning
// IDLE   | no grant held; pick next requester round-robin from last_grant+1
// LOCKED | grant held; forward beats of requester 'grant' until EOP accepted

module dmaster_st_packet_arbiter #(
  parameter int NUM_IN    = 2,
  parameter int DATA_W    = 8,
  parameter int CHANNEL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
);

  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt;
  logic [GW-1:0]     last_grant, last_grant_nxt;
  logic              can_load;
  logic              accept;
  logic              sel_valid;
  logic              sel_sop;
  logic              sel_eop;
  logic [DATA_W-1:0] sel_data;
  int                rr_idx;

  // in_ready depends only on state, grant and the buffer, never on in_valid.
  assign can_load  = !out_valid || out_ready;
  assign sel_valid = in_valid[grant];
  assign sel_sop   = in_startofpacket[grant];
  assign sel_eop   = in_endofpacket[grant];
  assign sel_data  = in_data[grant*DATA_W +: DATA_W];
  assign accept    = (state == LOCKED) && sel_valid && can_load;

  always_comb begin
    in_ready = '0;
    if (state == LOCKED) in_ready[grant] = can_load;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_IN - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    rr_idx         = 0;
    case (state)
      IDLE: begin
        // Scan offsets from farthest to nearest so the nearest valid
        // requester after last_grant is the final (winning) assignment.
        for (int k = NUM_IN; k >= 1; k--) begin
          rr_idx = (int'(last_grant) + k) % NUM_IN;
          if (in_valid[rr_idx]) begin
            grant_nxt = GW'(rr_idx);
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_eop) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer drains regardless of FSM state; a beat may still be waiting
  // downstream while the next packet is being arbitrated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_data          <= sel_data;
      out_channel       <= CHANNEL_W'(grant);
      out_startofpacket <= sel_sop;
      out_endofpacket   <= sel_eop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
